ws2812_pattern_gen: RTL and testbench
=====================================

WS2812_PATTERN_GEN -- requirements
Module: ws2812_pattern_gen

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8: number of LEDs on the strip, range 1..255.
REQ-002 SHALL have parameter FRAME_TICKS, default 524288: clk cycles in each frame-wait interval, minimum 2.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: high runs the pattern; low stops it after the current frame completes.
REQ-006 SHALL have port mode, input, 2: 0 colour-cycle, 1 chase, 2 bar, 3 alternate.
REQ-007 SHALL have port color_sel, input, 2: lit colour for modes 1-3; 0 red, 1 green, 2 blue, 3 white.
REQ-008 SHALL have port ready, input, 1: the downstream ws2812 driver can accept a write this cycle.
REQ-009 SHALL have port led_num, output, 8: LED index for the write.
REQ-010 SHALL have port rgb_data, output, 24: colour {R,G,B}, 8 bits each.
REQ-011 SHALL have port write, output, 1: single-cycle write strobe.
REQ-012 SHALL have port frame_done, output, 1: single-cycle pulse when a frame's writes are complete.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, UPDATE and ADVANCE.
REQ-014 IDLE: SHALL go to WAIT when enable=1, loading the tick counter with FRAME_TICKS-1.
REQ-015 WAIT: SHALL decrement the counter each cycle and go to UPDATE in the cycle after it reaches 0; total WAIT duration is FRAME_TICKS cycles.
REQ-016 On entry to UPDATE: SHALL latch mode and color_sel; if the latched mode differs from the previous latched mode, phase SHALL be cleared to 0 for this frame.
REQ-017 UPDATE: SHALL hold the current index idx (starting at 0), assert write for exactly one cycle only in a cycle where ready=1, and increment idx in that same cycle.
REQ-018 While ready=0: write SHALL be 0, and led_num and rgb_data SHALL be held.
REQ-019 led_num and rgb_data SHALL be valid in every cycle in which write=1.
REQ-020 After the write with idx=NUM_LEDS-1: SHALL go to ADVANCE; exactly NUM_LEDS writes are issued per frame.
REQ-021 ADVANCE: SHALL last one cycle, pulse frame_done, and update phase.
REQ-022 From ADVANCE: SHALL go to WAIT if enable=1, else to IDLE.
REQ-023 enable falling during WAIT: SHALL return to IDLE immediately with no writes; enable falling during UPDATE: the frame SHALL still complete.
REQ-024 Level L: L = brightness (macro on) or 8'h10 (macro off); palette colours are R={L,0,0}, G={0,L,0}, B={0,0,L}, W={L,L,L}.
REQ-025 Mode 0: every LED gets palette[phase mod 4]; phase steps 0,1,2,3,0.
REQ-026 Mode 1: LED idx==phase is lit, all others 0; phase wraps from NUM_LEDS-1 to 0.
REQ-027 Mode 2: LEDs with idx<phase are lit; phase steps 0..NUM_LEDS then wraps to 0, so an all-off frame occurs once per cycle.
REQ-028 Mode 3: LEDs with idx[0]==phase[0] are lit; phase toggles each frame.
REQ-029 All index and phase compares SHALL be unsigned, with no overflow for NUM_LEDS=255.

Reset
REQ-030 Asserting reset_n=0 SHALL asynchronously force: state IDLE, write=0, frame_done=0, led_num=0, rgb_data=0, phase=0, counter=0, latched mode=0.
REQ-031 Reset mid-UPDATE SHALL abort the frame with no further writes; after release, the first write SHALL be led_num=0 of a fresh frame.
REQ-032 Reset deassertion SHALL be synchronised internally (two-flop) before the FSM leaves IDLE.

Configuration
REQ-033 Macro WS2812_PATTERN_BRIGHTNESS_EN defined: SHALL add input port brightness [7:0], sampled at UPDATE entry, used as L.
REQ-034 Macro undefined: SHALL have no brightness port, and L SHALL be the constant 8'h10.

Verification
REQ-035 NUM_LEDS=8, FRAME_TICKS=16, mode=0, ready=1, macro off: first write occurs 16 cycles after WAIT entry; frames carry 24'h100000, 24'h001000, 24'h000010, 24'h101010 in order; 8 writes per frame on consecutive cycles.
REQ-036 mode=1, color_sel=1: in frame k, only led_num==k mod 8 has rgb_data=24'h001000; frame 8 has LED 0 lit again.
REQ-037 mode=2, color_sel=2: 9 consecutive frames have 0..8 LEDs lit at 24'h000010, then an all-off frame.
REQ-038 ready toggling 1,0,0,1 each cycle during UPDATE: exactly 8 writes with led_num 0..7 in order, no write while ready=0, and rgb_data stable while stalled.
REQ-039 reset_n pulsed low after the write of led_num=3: outputs go to 0 asynchronously; the next frame starts at led_num=0 with phase=0.
REQ-040 Macro on, brightness=8'hFF, mode=3, color_sel=3: even LEDs get 24'hFFFFFF and odd LEDs 0, swapping on the next frame; frame_done pulses once per frame.

Source files
------------

// File: rtl/ws2812_pattern_gen.sv
// Frame-paced LED pattern generator that writes one {R,G,B} word per LED to a ws2812 driver.
// Optional WS2812_PATTERN_BRIGHTNESS_EN adds a brightness input that sets the lit level.
module ws2812_pattern_gen #(
  parameter int NUM_LEDS    = 8,
  parameter int FRAME_TICKS = 524288
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [1:0]  color_sel,
  input  logic        ready,
`ifdef WS2812_PATTERN_BRIGHTNESS_EN
  input  logic [7:0]  brightness,
`endif
  output logic [7:0]  led_num,
  output logic [23:0] rgb_data,
  output logic        write,
  output logic        frame_done
);

  localparam int CW = $clog2(FRAME_TICKS);
  localparam logic [CW-1:0] TICK_LOAD = CW'(FRAME_TICKS - 1);
  localparam logic [7:0] LAST_IDX = 8'(NUM_LEDS - 1);
  localparam logic [7:0] NUM_IDX  = 8'(NUM_LEDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE, S_ADVANCE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    led_num_q, led_num_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    phase_q, phase_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    color_q, color_d;
  logic [1:0]    sync_q;
  logic [7:0]    lvl_in, lvl_cur;

`ifdef WS2812_PATTERN_BRIGHTNESS_EN
  logic [7:0] level_q, level_d;
  assign lvl_in  = brightness;
  assign lvl_cur = level_q;
`else
  assign lvl_in  = 8'h10;
  assign lvl_cur = 8'h10;
`endif

  function automatic logic [23:0] palette(input logic [1:0] sel, input logic [7:0] lv);
    case (sel)
      2'd0:    return {lv, 8'h00, 8'h00};
      2'd1:    return {8'h00, lv, 8'h00};
      2'd2:    return {8'h00, 8'h00, lv};
      default: return {lv, lv, lv};
    endcase
  endfunction

  function automatic logic [23:0] pixel(input logic [1:0] md, input logic [1:0] sel,
                                        input logic [7:0] lv, input logic [7:0] ph,
                                        input logic [7:0] idx);
    logic on;
    case (md)
      2'd0:    on = 1'b1;
      2'd1:    on = (idx == ph);
      2'd2:    on = (idx < ph);
      default: on = (idx[0] == ph[0]);
    endcase
    if (md == 2'd0) return palette(ph[1:0], lv);
    return on ? palette(sel, lv) : 24'h0;
  endfunction

  // Handshake: the block offers a word (led_num/rgb_data) for the whole UPDATE state;
  // a transfer happens in any UPDATE cycle with ready=1, and write marks exactly that cycle.
  assign write      = (state_q == S_UPDATE) && ready;
  assign led_num    = led_num_q;
  assign rgb_data   = rgb_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    led_num_d    = led_num_q;
    rgb_d        = rgb_q;
    frame_done_d = 1'b0;
    phase_d      = phase_q;
    mode_d       = mode_q;
    color_d      = color_q;
`ifdef WS2812_PATTERN_BRIGHTNESS_EN
    level_d      = level_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable && sync_q[1]) begin
          state_d = S_WAIT;
          cnt_d   = TICK_LOAD;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d   = S_UPDATE;
          mode_d    = mode;
          color_d   = color_sel;
`ifdef WS2812_PATTERN_BRIGHTNESS_EN
          level_d   = lvl_in;
`endif
          phase_d   = (mode != mode_q) ? 8'd0 : phase_q;
          led_num_d = 8'd0;
          rgb_d     = pixel(mode, color_sel, lvl_in, phase_d, 8'd0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_UPDATE: begin
        if (ready) begin
          if (led_num_q == LAST_IDX) begin
            state_d      = S_ADVANCE;
            frame_done_d = 1'b1;
          end else begin
            led_num_d = led_num_q + 8'd1;
            rgb_d     = pixel(mode_q, color_q, lvl_cur, phase_q, led_num_q + 8'd1);
          end
        end
      end
      default: begin
        case (mode_q)
          2'd0:    phase_d = {6'd0, phase_q[1:0] + 2'd1};
          2'd1:    phase_d = (phase_q == LAST_IDX) ? 8'd0 : phase_q + 8'd1;
          2'd2:    phase_d = (phase_q == NUM_IDX) ? 8'd0 : phase_q + 8'd1;
          default: phase_d = {7'd0, ~phase_q[0]};
        endcase
        if (enable) begin
          state_d = S_WAIT;
          cnt_d   = TICK_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= 2'b00;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      led_num_q    <= 8'd0;
      rgb_q        <= 24'h0;
      frame_done_q <= 1'b0;
      phase_q      <= 8'd0;
      mode_q       <= 2'd0;
      color_q      <= 2'd0;
`ifdef WS2812_PATTERN_BRIGHTNESS_EN
      level_q      <= 8'd0;
`endif
    end else begin
      sync_q       <= {sync_q[0], 1'b1};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      led_num_q    <= led_num_d;
      rgb_q        <= rgb_d;
      frame_done_q <= frame_done_d;
      phase_q      <= phase_d;
      mode_q       <= mode_d;
      color_q      <= color_d;
`ifdef WS2812_PATTERN_BRIGHTNESS_EN
      level_q      <= level_d;
`endif
    end
  end

endmodule

// File: tb/tb_ws2812_pattern_gen.sv
// Directed bench for ws2812_pattern_gen (NUM_LEDS=8, FRAME_TICKS=16): per-frame vector table
// plus hand-written sequences for stalls, enable drops and reset mid-frame.
module tb_ws2812_pattern_gen;

  localparam int N  = 8;
  localparam int FT = 16;
`ifdef WS2812_PATTERN_BRIGHTNESS_EN
  localparam logic [7:0] L = 8'hFF;
`else
  localparam logic [7:0] L = 8'h10;
`endif
  localparam logic [23:0] C_R = {L, 8'h00, 8'h00};
  localparam logic [23:0] C_G = {8'h00, L, 8'h00};
  localparam logic [23:0] C_B = {8'h00, 8'h00, L};
  localparam logic [23:0] C_W = {L, L, L};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [1:0]  color_sel = 2'd0;
  logic        ready = 1'b1;
  logic [7:0]  led_num;
  logic [23:0] rgb_data;
  logic        write;
  logic        frame_done;
`ifdef WS2812_PATTERN_BRIGHTNESS_EN
  logic [7:0]  brightness = 8'hFF;
`endif

  ws2812_pattern_gen #(.NUM_LEDS(N), .FRAME_TICKS(FT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .mode       (mode),
    .color_sel  (color_sel),
    .ready      (ready),
`ifdef WS2812_PATTERN_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .led_num    (led_num),
    .rgb_data   (rgb_data),
    .write      (write),
    .frame_done (frame_done)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;
  int last_fd = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Runs until one frame_done, checking every write against {mask, col}.
  task automatic collect_frame(input logic [7:0] mask, input logic [23:0] col,
                               input bit stall, input bit drop_en, input bit gap_chk);
    int n = 0;
    int lastw = -1;
    bit done = 0;
    logic [3:0] pat = 4'b1001;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk);
      #1 ready = stall ? pat[k % 4] : 1'b1;
      @(negedge clk);
      if (write) begin
        check("write_only_when_ready", {31'd0, ready}, 32'd1);
        if (n < N) begin
          check("led_num", {24'd0, led_num}, n);
          check("rgb_data", {8'd0, rgb_data}, {8'd0, (mask[n] ? col : 24'h0)});
        end else begin
          check("extra_write", n, N - 1);
        end
        if (gap_chk && !stall) begin
          if (n == 0 && last_fd >= 0) check("wait_latency", cyc - last_fd, 17);
          if (n > 0) check("consecutive_write", cyc - lastw, 1);
        end
        lastw = cyc;
        n++;
        if (drop_en) enable = 1'b0;
      end else if (stall && !ready && n > 0 && n < N) begin
        check("held_led_num", {24'd0, led_num}, n);
        check("held_rgb_data", {8'd0, rgb_data}, {8'd0, (mask[n] ? col : 24'h0)});
      end
      if (frame_done) begin
        done = 1;
        check("writes_per_frame", n, N);
        if (gap_chk && !stall) check("done_latency", cyc - lastw, 1);
        last_fd = cyc;
      end
    end
    check("frame_done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("frame_done_single", {31'd0, frame_done}, 32'd0);
    ready = 1'b1;
  endtask

  task automatic count_idle_writes(input int cycles, input string name);
    int w = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (write || frame_done) w++;
    end
    check(name, w, 0);
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [1:0]  csel;
    logic [7:0]  mask;
    logic [23:0] col;
    bit          stall;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] md, input logic [1:0] csel,
                              input logic [7:0] mask, input logic [23:0] col, input bit stall);
    vec_t v;
    v.md = md; v.csel = csel; v.mask = mask; v.col = col; v.stall = stall;
    vecs.push_back(v);
  endfunction

  initial begin
    int found;
    // colour cycle (color_sel ignored), wrapping back to red
    add(0, 1, 8'hFF, C_R, 0); add(0, 1, 8'hFF, C_G, 0); add(0, 1, 8'hFF, C_B, 0);
    add(0, 1, 8'hFF, C_W, 0); add(0, 1, 8'hFF, C_R, 0);
    // chase, frame 8 back on LED 0
    add(1, 1, 8'h01, C_G, 0); add(1, 1, 8'h02, C_G, 0); add(1, 1, 8'h04, C_G, 0);
    add(1, 1, 8'h08, C_G, 0); add(1, 1, 8'h10, C_G, 0); add(1, 1, 8'h20, C_G, 0);
    add(1, 1, 8'h40, C_G, 0); add(1, 1, 8'h80, C_G, 0); add(1, 1, 8'h01, C_G, 0);
    // bar: 0..8 lit, then all-off again
    add(2, 2, 8'h00, C_B, 0); add(2, 2, 8'h01, C_B, 0); add(2, 2, 8'h03, C_B, 0);
    add(2, 2, 8'h07, C_B, 0); add(2, 2, 8'h0F, C_B, 0); add(2, 2, 8'h1F, C_B, 0);
    add(2, 2, 8'h3F, C_B, 0); add(2, 2, 8'h7F, C_B, 0); add(2, 2, 8'hFF, C_B, 0);
    add(2, 2, 8'h00, C_B, 0);
    // alternate: even, odd, even
    add(3, 3, 8'h55, C_W, 0); add(3, 3, 8'hAA, C_W, 0); add(3, 3, 8'h55, C_W, 0);
    // back to colour cycle (phase cleared) under ready stalls, then unstalled
    add(0, 0, 8'hFF, C_R, 1); add(0, 0, 8'hFF, C_G, 0);

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_write", {31'd0, write}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    check("reset_led_num", {24'd0, led_num}, 32'd0);
    check("reset_rgb_data", {8'd0, rgb_data}, 32'd0);

    enable = 1'b1;
    reset_n = 1'b1;
    foreach (vecs[i]) begin
      mode = vecs[i].md;
      color_sel = vecs[i].csel;
      collect_frame(vecs[i].mask, vecs[i].col, vecs[i].stall, 1'b0, 1'b1);
    end

    // enable dropped mid-UPDATE: frame completes, then idle; phase kept
    collect_frame(8'hFF, C_B, 1'b0, 1'b1, 1'b1);
    count_idle_writes(40, "idle_after_update_drop");
    enable = 1'b1;
    last_fd = -1;
    collect_frame(8'hFF, C_W, 1'b0, 1'b0, 1'b0);

    // enable dropped during WAIT: no writes at all
    @(posedge clk);
    #1 enable = 1'b0;
    count_idle_writes(30, "idle_after_wait_drop");
    enable = 1'b1;
    last_fd = -1;
    collect_frame(8'hFF, C_R, 1'b0, 1'b0, 0);

    // reset after the write of LED 3 in the green frame
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (write && led_num == 8'd3) begin
        found = 1;
        check("pre_reset_rgb", {8'd0, rgb_data}, {8'd0, C_G});
        break;
      end
    end
    check("abort_point_seen", found, 1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_write", {31'd0, write}, 32'd0);
    check("async_reset_frame_done", {31'd0, frame_done}, 32'd0);
    check("async_reset_led_num", {24'd0, led_num}, 32'd0);
    check("async_reset_rgb_data", {8'd0, rgb_data}, 32'd0);
    count_idle_writes(3, "no_write_in_reset");
    reset_n = 1'b1;
    last_fd = -1;
    collect_frame(8'hFF, C_R, 1'b0, 1'b0, 1'b0);
    collect_frame(8'hFF, C_G, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
